// File: rtl/det_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : det_seq_driver
// Purpose  : Sequencer for a serial run-length detector. Latches a parallel
//            test word, resets the detector, shifts the word in MSB-first
//            and collects hit statistics (count, first hit index), reporting
//            completion through a busy/done handshake.
// Option   : SEQ_DRV_RESTART_EN - when defined, start during CLR/SHIFT/DRAIN
//            aborts the current run and restarts with a freshly latched word.
// Revision : 1.0 - initial release
// ============================================================================
module det_seq_driver #(
    parameter int W  = 16,  // pattern length in bits (>= 4)
    parameter int CW = 5    // counter/index width, 2^CW > W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [W-1:0]  pattern_i,
    input  logic          det_out_i,
    output logic          det_in_o,
    output logic          det_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] hit_cnt_o,
    output logic [CW-1:0] first_hit_o,
    output logic          first_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [W-1:0]  shreg_q;
    logic [CW-1:0] bit_q;
    logic          det_in_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] hit_cnt_q;
    logic [CW-1:0] first_hit_q;
    logic          first_valid_q;

    logic          samp_en_d;
    logic [CW-1:0] samp_idx_d;
    logic [CW-1:0] hit_cnt_d;
    logic [CW-1:0] first_hit_d;
    logic          first_valid_d;

    // Detector output lags det_in by one cycle: in SHIFT cycle i it describes
    // bit i-1, and DRAIN picks up the last bit. Cycle 0 sees a fresh detector.
    always_comb begin
        samp_en_d     = 1'b0;
        samp_idx_d    = bit_q - CW'(1);
        hit_cnt_d     = hit_cnt_q;
        first_hit_d   = first_hit_q;
        first_valid_d = first_valid_q;
        if (state_q == S_SHIFT && bit_q != '0) begin
            samp_en_d = 1'b1;
        end
        if (state_q == S_DRAIN) begin
            samp_en_d  = 1'b1;
            samp_idx_d = CW'(W - 1);
        end
        if (samp_en_d && det_out_i) begin
            if (hit_cnt_q != '1) begin
                hit_cnt_d = hit_cnt_q + CW'(1);
            end
            if (!first_valid_q) begin
                first_valid_d = 1'b1;
                first_hit_d   = samp_idx_d;
            end
        end
    end

    // Sequencer FSM with registered handshake, serial data and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_q         <= '0;
            det_in_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hit_cnt_q     <= '0;
            first_hit_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            hit_cnt_q     <= hit_cnt_d;
            first_hit_q   <= first_hit_d;
            first_valid_q <= first_valid_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        shreg_q       <= pattern_i;
                        bit_q         <= '0;
                        det_in_q      <= 1'b0;
                        busy_q        <= 1'b1;
                        hit_cnt_q     <= '0;
                        first_hit_q   <= '0;
                        first_valid_q <= 1'b0;
                        state_q       <= S_CLR;
                    end
                end
                S_CLR: begin
                    // Present the MSB for SHIFT cycle 0
                    det_in_q <= shreg_q[W-1];
                    shreg_q  <= {shreg_q[W-2:0], 1'b0};
                    bit_q    <= '0;
                    state_q  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_q == CW'(W - 1)) begin
                        det_in_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else begin
                        det_in_q <= shreg_q[W-1];
                        shreg_q  <= {shreg_q[W-2:0], 1'b0};
                        bit_q    <= bit_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    det_in_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef SEQ_DRV_RESTART_EN
            // Abort an in-flight run and start over; no done for the old run
            if (start_i && (state_q == S_CLR || state_q == S_SHIFT ||
                            state_q == S_DRAIN)) begin
                shreg_q       <= pattern_i;
                bit_q         <= '0;
                det_in_q      <= 1'b0;
                busy_q        <= 1'b1;
                done_q        <= 1'b0;
                hit_cnt_q     <= '0;
                first_hit_q   <= '0;
                first_valid_q <= 1'b0;
                state_q       <= S_CLR;
            end
`endif
        end
    end

    assign det_in_o      = det_in_q;
    assign det_rst_o     = reset | (state_q == S_CLR);
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign first_hit_o   = first_hit_q;
    assign first_valid_o = first_valid_q;

endmodule
`default_nettype wire
